// File: rtl/spi_dac_ctrl.sv
// spi_dac_ctrl: SPI master for serial DACs.
//
// Takes one DATA_W-bit sample per valid/ready handshake and shifts it out on
// mosi/sclk while cs is held low. The data is driven on the trailing sclk edge
// and sampled by the DAC on the leading edge. Clock polarity, bit order, sclk
// rate and the cs gap between frames are all parameters.
//
// Optional feature macro: SPI_DAC_CTRL_LDAC_EN adds an ldac_n strobe, low for
// one half-period right after cs rises, with done moved to its end.
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high
//   in_valid  sample offered
//   in_data   sample (DATA_W bits)
//   in_ready  high only while idle
//   busy      ~in_ready
//   done      one-clk pulse at frame completion
//   mosi      serial data (registered)
//   sclk      serial clock (registered)
//   cs        chip select, active low (registered)
//   ldac_n    DAC load strobe, active low (only with SPI_DAC_CTRL_LDAC_EN)
module spi_dac_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DIV       = 50,
  parameter logic        CPOL      = 1'b0,
  parameter logic        MSB_FIRST = 1'b1,
  parameter int unsigned CS_GAP    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              mosi,
  output logic              sclk,
`ifdef SPI_DAC_CTRL_LDAC_EN
  output logic              ldac_n,
`endif
  output logic              cs
);

  localparam int unsigned DivW = $clog2(DIV);
  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam int unsigned GapW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  localparam logic [DivW-1:0] DivMax  = DivW'(DIV - 1);
  localparam logic [CntW-1:0] CntInit = CntW'(DATA_W);
  localparam logic [GapW-1:0] GapLast = GapW'((CS_GAP > 0) ? (CS_GAP - 1) : 0);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSetup = 3'd1;
  localparam logic [2:0] StShift = 3'd2;
  localparam logic [2:0] StHold  = 3'd3;
  localparam logic [2:0] StGap   = 3'd4;
`ifdef SPI_DAC_CTRL_LDAC_EN
  localparam logic [2:0] StLdac  = 3'd5;
`endif

  logic [2:0]        state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              cs_q, cs_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              done_q, done_d;
`ifdef SPI_DAC_CTRL_LDAC_EN
  logic              ldac_q, ldac_d;
`endif

  logic              tick;
  logic              gap_exit;
  logic              first_bit;
  logic              next_bit;
  logic [DATA_W-1:0] shifted;

  assign tick = (div_q == DivMax);

  always_comb begin
    first_bit = MSB_FIRST ? in_data[DATA_W-1] : in_data[0];
    shifted   = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
    next_bit  = MSB_FIRST ? shifted[DATA_W-1] : shifted[0];
  end

  always_comb begin
    state_d  = state_q;
    div_d    = tick ? '0 : div_q + DivW'(1);
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    shreg_d  = shreg_q;
    cs_d     = cs_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    done_d   = 1'b0;
    gap_exit = 1'b0;
`ifdef SPI_DAC_CTRL_LDAC_EN
    ldac_d   = ldac_q;
`endif

    case (state_q)
      StIdle: begin
        div_d = '0;
      end
      // The setup tick is also the first leading sclk edge.
      StSetup: begin
        if (tick) begin
          sclk_d  = ~CPOL;
          cnt_d   = cnt_q - CntW'(1);
          state_d = StShift;
        end
      end
      StShift: begin
        if (tick) begin
          if (sclk_q == CPOL) begin
            sclk_d = ~CPOL;
            cnt_d  = cnt_q - CntW'(1);
          end else begin
            sclk_d = CPOL;
            if (cnt_q != '0) begin
              shreg_d = shifted;
              mosi_d  = next_bit;
            end else begin
              state_d = StHold;
            end
          end
        end
      end
      StHold: begin
        if (tick) begin
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
`ifdef SPI_DAC_CTRL_LDAC_EN
          ldac_d  = 1'b0;
          state_d = StLdac;
`else
          done_d  = 1'b1;
          gap_d   = '0;
          state_d = StGap;
`endif
        end
      end
`ifdef SPI_DAC_CTRL_LDAC_EN
      StLdac: begin
        if (tick) begin
          ldac_d  = 1'b1;
          done_d  = 1'b1;
          gap_d   = '0;
          state_d = StGap;
        end
      end
`endif
      StGap: begin
        if (CS_GAP == 0) begin
          gap_exit = 1'b1;
        end else if (tick) begin
          if (gap_q == GapLast) gap_exit = 1'b1;
          else                  gap_d    = gap_q + GapW'(1);
        end
        if (gap_exit) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A sample held on in_valid is taken on the edge that ends the gap, so
    // back-to-back frames see no extra idle cycle.
    if (in_valid && ((state_q == StIdle) || gap_exit)) begin
      shreg_d = in_data;
      cs_d    = 1'b0;
      mosi_d  = first_bit;
      cnt_d   = CntInit;
      state_d = StSetup;
    end

    // Every phase starts on a fresh half-period.
    if (state_d != state_q) div_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      div_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      shreg_q <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= CPOL;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SPI_DAC_CTRL_LDAC_EN
      ldac_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      shreg_q <= shreg_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
`ifdef SPI_DAC_CTRL_LDAC_EN
      ldac_q  <= ldac_d;
`endif
    end
  end

  assign in_ready = (state_q == StIdle);
  assign busy     = ~in_ready;
  assign done     = done_q;
  assign mosi     = mosi_q;
  assign sclk     = sclk_q;
  assign cs       = cs_q;
`ifdef SPI_DAC_CTRL_LDAC_EN
  assign ldac_n   = ldac_q;
`endif

endmodule

// File: tb/tb_spi_dac_ctrl.sv
// Bench for spi_dac_ctrl: three instances (8-bit MSB-first CPOL=0, 4-bit
// LSB-first CPOL=1, 8-bit with CS_GAP=0), all DIV=4. Each frame is captured
// cycle by cycle from the accept edge and checked against hand-computed
// timing and bit sequences.
module tb_spi_dac_ctrl;

`ifdef SPI_DAC_CTRL_LDAC_EN
  localparam int LD = 4;
`else
  localparam int LD = 0;
`endif

  localparam int BMosi  = 0;
  localparam int BSclk  = 1;
  localparam int BCs    = 2;
  localparam int BDone  = 3;
  localparam int BReady = 4;
  localparam int BBusy  = 5;
  localparam int BLdac  = 6;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  int         sel;

  logic a_ready, a_busy, a_done, a_mosi, a_sclk, a_cs, a_ldac;
  logic b_ready, b_busy, b_done, b_mosi, b_sclk, b_cs, b_ldac;
  logic c_ready, c_busy, c_done, c_mosi, c_sclk, c_cs, c_ldac;
  logic m_ready, m_busy, m_done, m_mosi, m_sclk, m_cs, m_ldac;

  logic [6:0] cap [0:255];
  int n_checks;
  int n_errors;

  spi_dac_ctrl #(.DATA_W(8), .DIV(4), .CPOL(1'b0), .MSB_FIRST(1'b1), .CS_GAP(2)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid && (sel == 0)), .in_data(in_data),
    .in_ready(a_ready), .busy(a_busy), .done(a_done), .mosi(a_mosi), .sclk(a_sclk),
`ifdef SPI_DAC_CTRL_LDAC_EN
    .ldac_n(a_ldac),
`endif
    .cs(a_cs)
  );

  spi_dac_ctrl #(.DATA_W(4), .DIV(4), .CPOL(1'b1), .MSB_FIRST(1'b0), .CS_GAP(2)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid && (sel == 1)), .in_data(in_data[3:0]),
    .in_ready(b_ready), .busy(b_busy), .done(b_done), .mosi(b_mosi), .sclk(b_sclk),
`ifdef SPI_DAC_CTRL_LDAC_EN
    .ldac_n(b_ldac),
`endif
    .cs(b_cs)
  );

  spi_dac_ctrl #(.DATA_W(8), .DIV(4), .CPOL(1'b0), .MSB_FIRST(1'b1), .CS_GAP(0)) u_c (
    .clk(clk), .reset(reset), .in_valid(in_valid && (sel == 2)), .in_data(in_data),
    .in_ready(c_ready), .busy(c_busy), .done(c_done), .mosi(c_mosi), .sclk(c_sclk),
`ifdef SPI_DAC_CTRL_LDAC_EN
    .ldac_n(c_ldac),
`endif
    .cs(c_cs)
  );

`ifndef SPI_DAC_CTRL_LDAC_EN
  assign a_ldac = 1'b1;
  assign b_ldac = 1'b1;
  assign c_ldac = 1'b1;
`endif

  always_comb begin
    {m_ldac, m_busy, m_ready, m_done, m_cs, m_sclk, m_mosi} =
        {a_ldac, a_busy, a_ready, a_done, a_cs, a_sclk, a_mosi};
    if (sel == 1)
      {m_ldac, m_busy, m_ready, m_done, m_cs, m_sclk, m_mosi} =
          {b_ldac, b_busy, b_ready, b_done, b_cs, b_sclk, b_mosi};
    else if (sel == 2)
      {m_ldac, m_busy, m_ready, m_done, m_cs, m_sclk, m_mosi} =
          {c_ldac, c_busy, c_ready, c_done, c_cs, c_sclk, c_mosi};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  // Cycle n is sampled at the falling edge after accept edge T0+n. A held
  // in_valid is dropped once the following frame's cs fall is seen.
  task automatic capture(input int ncyc);
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      cap[n] = {m_ldac, m_busy, m_ready, m_done, m_cs, m_sclk, m_mosi};
      if (n > 0 && cap[n-1][BCs] && !cap[n][BCs]) in_valid = 1'b0;
    end
  endtask

  task automatic start(input logic [7:0] d);
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic int first_at(input int b, input logic v, input int from, input int upto);
    for (int n = from; n <= upto; n++) if (cap[n][b] == v) return n;
    return -1;
  endfunction

  function automatic int count_at(input int b, input logic v, input int from, input int upto);
    int c;
    c = 0;
    for (int n = from; n <= upto; n++) if (cap[n][b] == v) c++;
    return c;
  endfunction

  // Bits seen by the DAC on leading edges, first bit ending up most significant.
  function automatic int lead_bits(input logic cpol, input int from, input int upto);
    logic [7:0] r;
    r = '0;
    for (int n = from + 1; n <= upto; n++)
      if (cap[n-1][BSclk] == cpol && cap[n][BSclk] != cpol) r = {r[6:0], cap[n-1][BMosi]};
    return int'(r);
  endfunction

  function automatic int first_lead(input logic cpol, input int from, input int upto);
    for (int n = from + 1; n <= upto; n++)
      if (cap[n-1][BSclk] == cpol && cap[n][BSclk] != cpol) return n;
    return -1;
  endfunction

  function automatic int toggles(input int from, input int upto);
    int c;
    c = 0;
    for (int n = from + 1; n <= upto; n++) if (cap[n-1][BSclk] != cap[n][BSclk]) c++;
    return c;
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    sel      = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs", int'(m_cs), 1);
    check("rst_sclk", int'(m_sclk), 0);
    check("rst_mosi", int'(m_mosi), 0);
    check("rst_done", int'(m_done), 0);
    check("rst_ready", int'(m_ready), 1);
    check("rst_busy", int'(m_busy), 0);
    check("rst_ldac", int'(m_ldac), 1);
    check("rst_b_sclk", int'(b_sclk), 1);
    reset = 1'b0;

    // Single frame 0xA5; in_data changes while busy must be ignored.
    start(8'hA5);
    in_valid = 1'b0;
    in_data  = 8'h00;
    capture(84 + LD);
    check("a_cs_fall", int'(cap[0][BCs]), 0);
    check("a_busy", int'(cap[0][BBusy]), 1);
    check("a_first_lead", first_lead(1'b0, 0, 83 + LD), 4);
    check("a_bits", lead_bits(1'b0, 0, 83 + LD), 'hA5);
    check("a_toggles", toggles(0, 83 + LD), 16);
    check("a_cs_low", count_at(BCs, 1'b0, 0, 83 + LD), 68);
    check("a_cs_rise", first_at(BCs, 1'b1, 0, 83 + LD), 68);
    check("a_mosi_end", int'(cap[68][BMosi]), 0);
    check("a_done_at", first_at(BDone, 1'b1, 0, 83 + LD), 68 + LD);
    check("a_done_cnt", count_at(BDone, 1'b1, 0, 83 + LD), 1);
    check("a_ready_at", first_at(BReady, 1'b1, 0, 83 + LD), 76 + LD);
`ifdef SPI_DAC_CTRL_LDAC_EN
    check("a_ldac_at", first_at(BLdac, 1'b0, 0, 83 + LD), 68);
    check("a_ldac_cnt", count_at(BLdac, 1'b0, 0, 83 + LD), 4);
`endif

    // Back-to-back with in_valid held: 0x3C then 0xC3.
    start(8'h3C);
    in_data = 8'hC3;
    capture(160 + 2 * LD);
    check("bb_bits1", lead_bits(1'b0, 0, 75 + LD), 'h3C);
    check("bb_cs_fall2", first_at(BCs, 1'b0, 68 + LD, 159 + 2 * LD), 76 + LD);
    check("bb_bits2", lead_bits(1'b0, 76 + LD, 159 + 2 * LD), 'hC3);
    check("bb_no_idle", count_at(BReady, 1'b1, 0, 151 + 2 * LD), 0);
    check("bb_done2", first_at(BDone, 1'b1, 76 + LD, 159 + 2 * LD), 144 + 2 * LD);
    check("bb_ready", first_at(BReady, 1'b1, 77 + LD, 159 + 2 * LD), 152 + 2 * LD);

    // CPOL=1, LSB first, 4-bit frame 0x6.
    sel = 1;
    @(negedge clk);
    check("c_sclk_idle", int'(m_sclk), 1);
    start(8'h06);
    in_valid = 1'b0;
    in_data  = 8'h00;
    capture(50 + LD);
    check("c_bits", lead_bits(1'b1, 0, 49 + LD), 'h06);
    check("c_toggles", toggles(0, 49 + LD), 8);
    check("c_cs_low", count_at(BCs, 1'b0, 0, 49 + LD), 36);
    check("c_sclk_end", int'(cap[36][BSclk]), 1);
    check("c_ready_at", first_at(BReady, 1'b1, 0, 49 + LD), 44 + LD);

    // Reset asserted at cycle 30 of a frame.
    sel = 0;
    start(8'hFF);
    in_valid = 1'b0;
    capture(30);
    check("r_cs_before", int'(cap[29][BCs]), 0);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    #1;
    check("r_cs", int'(m_cs), 1);
    check("r_sclk", int'(m_sclk), 0);
    check("r_mosi", int'(m_mosi), 0);
    check("r_ready", int'(m_ready), 1);
    repeat (2) begin
      @(negedge clk);
      check("r_no_done", int'(m_done), 0);
      check("r_no_accept", int'(m_cs), 1);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    capture(80 + LD);
    check("r_cs_fall", int'(cap[0][BCs]), 0);
    check("r_first_lead", first_lead(1'b0, 0, 79 + LD), 4);
    check("r_bits", lead_bits(1'b0, 0, 79 + LD), 'h5A);
    check("r_done_at", first_at(BDone, 1'b1, 0, 79 + LD), 68 + LD);

    // CS_GAP=0, back-to-back 0x81 then 0x7E.
    sel = 2;
    start(8'h81);
    in_data = 8'h7E;
    capture(150 + 2 * LD);
    check("g_bits1", lead_bits(1'b0, 0, 68 + LD), 'h81);
    check("g_cs_rise", first_at(BCs, 1'b1, 0, 149 + 2 * LD), 68);
    check("g_cs_fall2", first_at(BCs, 1'b0, 68 + LD, 149 + 2 * LD), 69 + LD);
    check("g_cs_high", count_at(BCs, 1'b1, 0, 130), 1 + LD);
    check("g_bits2", lead_bits(1'b0, 69 + LD, 149 + 2 * LD), 'h7E);
    check("g_done2", first_at(BDone, 1'b1, 70 + LD, 149 + 2 * LD), 137 + 2 * LD);
    check("g_ready", first_at(BReady, 1'b1, 70 + LD, 149 + 2 * LD), 138 + 2 * LD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_dac_ctrl.md
# spi_dac_ctrl

Parametrised SPI master for serial DACs. It accepts one DATA_W-bit sample per valid/ready handshake and shifts it out on mosi/sclk under an active-low chip select. Clock polarity, bit order, SCLK rate and the inter-frame gap are all parameters, and done marks the end of each frame. It sits between the counter/sample source and the board DAC pins, replacing the fixed 8-bit, free-running DAC driver.

## Interface
- DATA_W, 8: frame width in bits; must be ≥1.
- DIV, 50: SCLK half-period in clk cycles; must be ≥2.
- CPOL, 0: SCLK idle level. Phase is fixed: data is driven on the trailing edge and sampled by the DAC on the leading edge.
- MSB_FIRST, 1: 1 sends the MSB first; 0 sends the LSB first.
- CS_GAP, 2: half-periods cs stays high after a frame before the next accept; 0 is legal.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  sample offered.
- in_data  in  DATA_W  sample.
- in_ready  out  1  high only in IDLE; decoded from state.
- busy  out  1  equals ~in_ready.
- done  out  1  one-clk pulse at frame completion.
- mosi  out  1  serial data, registered.
- sclk  out  1  serial clock, registered.
- cs  out  1  chip select, active low, registered.

## Operation
- Reset values (asynchronous): state IDLE, cs=1, sclk=CPOL, mosi=0, done=0, divider=0, bit counter=0. in_ready=1, busy=0.
- Nothing is accepted while reset is high. A sample valid on the first edge after release is accepted.
- Divider counts 0..DIV-1. A tick occurs when it reaches DIV-1. The divider is cleared on accept and on every state change, so every phase lasts a whole number of half-periods.
- States:
  - IDLE: waits for in_valid && in_ready at a clk edge. On that edge: latch in_data into the shift register, cs<=0, mosi<=first bit, bit counter<=DATA_W, go SETUP. in_data changes while busy are ignored.
  - SETUP: one half-period, then go SHIFT.
  - SHIFT: sclk toggles on every tick.
    - Leading edge: decrement the bit counter.
    - Trailing edge: if the counter is nonzero, shift and drive the next bit on mosi; if it is zero, go HOLD (sclk is back at CPOL).
  - HOLD: one half-period. On the tick: cs<=1, mosi<=0, done<=1 for one cycle, go GAP.
  - GAP: CS_GAP half-periods, then IDLE. With CS_GAP=0, GAP exits in the same cycle it is entered, so IDLE is reached on the next edge.
- Bit order: MSB_FIRST=1 shifts left and sends data[DATA_W-1] first. MSB_FIRST=0 shifts right and sends data[0] first.
- Widths: divider uses $clog2(DIV) bits; bit counter uses $clog2(DATA_W+1) bits; no other arithmetic.
- Reset mid-frame: immediate return to reset values, no done pulse, and the partial frame is discarded.

## Timing
- Accept at edge T0 (cycle 0). cs falls in cycle 0.
- Leading SCLK edges at T0+DIV·(1+2k); trailing edges at T0+DIV·(2+2k), for k=0..DATA_W-1.
- cs low for DIV·(2·DATA_W+1) cycles. done and cs rise at T0+DIV·(2·DATA_W+1).
- in_ready returns at T0+DIV·(2·DATA_W+1+CS_GAP).
- Back-to-back: if in_valid is held, the next accept happens on the first IDLE edge, giving zero extra idle cycles.
- mosi is stable for ≥DIV cycles on both sides of every leading edge.

## Configuration
- Macro: SPI_DAC_CTRL_LDAC_EN.
- Defined:
  - Adds output port ldac_n (1 bit, reset 1) and state LDAC, inserted between HOLD and GAP.
  - ldac_n is low for exactly DIV cycles, starting the cycle cs rises.
  - done moves to the cycle ldac_n returns high.
  - in_ready is delayed by an extra DIV cycles.
- Undefined: no ldac_n port, no LDAC state, and timing as stated above.

## Test plan
- DATA_W=8, DIV=4, CS_GAP=2, CPOL=0, MSB_FIRST=1; send 0xA5 → bits sampled at rising sclk are 1,0,1,0,0,1,0,1; cs low 68 cycles; done at cycle 68; in_ready at cycle 76.
- Same configuration, in_valid held high with 0x3C then 0xC3 → second cs fall at cycle 76; second frame bits 1,1,0,0,0,0,1,1.
- CPOL=1, MSB_FIRST=0, DATA_W=4, data 0x6 → sclk idles 1; bits sampled at falling edges are 0,1,1,0; 8 sclk transitions per frame.
- Assert reset at cycle 30 of a frame → cs=1, sclk=CPOL, mosi=0 immediately; no done pulse; after release, a new accept restarts the timing from the accept edge.
- CS_GAP=0 with back-to-back samples → cs high for exactly 1 cycle between frames.
- With SPI_DAC_CTRL_LDAC_EN defined, DIV=4, DATA_W=8 → ldac_n low during cycles 68–71; done at cycle 72; in_ready at cycle 80.
